// File: rtl/req_delay_line.sv
// Multi-channel programmable matched-delay line: each channel's req edges are
// reproduced on ack after dly_cur cycles, with pulses/gaps shorter than the delay filtered.
module req_delay_line #(
   parameter int CHANNELS      = 4,
   parameter int MAX_DELAY     = 15,
   parameter int DEFAULT_DELAY = 12,
   parameter bit TRACK_FALL    = 1'b1,
   localparam int DLY_W        = $clog2(MAX_DELAY + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                cfg_load,
   input  logic [DLY_W-1:0]    cfg_delay,
   output logic                cfg_err,
   output logic [DLY_W-1:0]    dly_cur,
   input  logic [CHANNELS-1:0] req,
   output logic [CHANNELS-1:0] ack,
   output logic [CHANNELS-1:0] busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RISE = 2'd1,
      ST_HIGH = 2'd2,
      ST_FALL = 2'd3
   } state_t;

   localparam logic [DLY_W-1:0] MAX_D  = DLY_W'(MAX_DELAY);
   localparam logic [DLY_W-1:0] DEF_D  = DLY_W'(DEFAULT_DELAY);
   localparam logic [DLY_W-1:0] ZERO_D = DLY_W'(1'b0);
   localparam logic [DLY_W-1:0] ONE_D  = DLY_W'(1'b1);

   logic [DLY_W-1:0]    dly_cur_r;
   logic                cfg_err_r;
   logic [CHANNELS-1:0] ack_vec_s;
   logic [CHANNELS-1:0] busy_vec_s;
   logic                cfg_ok_s;
   logic                d_zero_s;
   logic [DLY_W-1:0]    d_minus1_s;

   // Shared decode of the delay register and config-load acceptance
   always_comb begin
      d_zero_s   = (dly_cur_r == ZERO_D);
      d_minus1_s = dly_cur_r - ONE_D;
      if (cfg_load && (busy_vec_s == {CHANNELS{1'b0}}) && (cfg_delay <= MAX_D)) begin
         cfg_ok_s = 1'b1;
      end else begin
         cfg_ok_s = 1'b0;
      end
   end

   // Delay register and one-cycle reject flag; transitions starting this edge still see the old D
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dly_cur_r <= DEF_D;
         cfg_err_r <= 1'b0;
      end else begin
         if (cfg_ok_s) begin
            dly_cur_r <= cfg_delay;
         end else begin
            dly_cur_r <= dly_cur_r;
         end
         cfg_err_r <= cfg_load & ~cfg_ok_s;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      state_t           state_r;
      state_t           state_nxt_s;
      logic [DLY_W-1:0] cnt_r;
      logic [DLY_W-1:0] cnt_nxt_s;
      logic             ack_ch_r;
      logic             busy_ch_r;

      // Per-channel next state; a low enable overrides everything and flushes the channel
      always_comb begin
         state_nxt_s = state_r;
         cnt_nxt_s   = cnt_r;
         if (!en) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = ZERO_D;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (req[g]) begin
                     if (d_zero_s) begin
                        state_nxt_s = ST_HIGH;
                        cnt_nxt_s   = ZERO_D;
                     end else begin
                        state_nxt_s = ST_RISE;
                        cnt_nxt_s   = d_minus1_s;
                     end
                  end else begin
                     state_nxt_s = ST_IDLE;
                     cnt_nxt_s   = ZERO_D;
                  end
               end
               ST_RISE: begin
                  if (!req[g]) begin
                     state_nxt_s = ST_IDLE;
                     cnt_nxt_s   = ZERO_D;
                  end else if (cnt_r == ZERO_D) begin
                     state_nxt_s = ST_HIGH;
                     cnt_nxt_s   = ZERO_D;
                  end else begin
                     state_nxt_s = ST_RISE;
                     cnt_nxt_s   = cnt_r - ONE_D;
                  end
               end
               ST_HIGH: begin
                  if (!req[g]) begin
                     if (!TRACK_FALL || d_zero_s) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = ZERO_D;
                     end else begin
                        state_nxt_s = ST_FALL;
                        cnt_nxt_s   = d_minus1_s;
                     end
                  end else begin
                     state_nxt_s = ST_HIGH;
                     cnt_nxt_s   = ZERO_D;
                  end
               end
               ST_FALL: begin
                  if (req[g]) begin
                     state_nxt_s = ST_HIGH;
                     cnt_nxt_s   = ZERO_D;
                  end else if (cnt_r == ZERO_D) begin
                     state_nxt_s = ST_IDLE;
                     cnt_nxt_s   = ZERO_D;
                  end else begin
                     state_nxt_s = ST_FALL;
                     cnt_nxt_s   = cnt_r - ONE_D;
                  end
               end
               default: begin
                  state_nxt_s = ST_IDLE;
                  cnt_nxt_s   = ZERO_D;
               end
            endcase
         end
      end

      // State, counter and outputs registered together so ack/busy match the new state
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= ZERO_D;
            ack_ch_r  <= 1'b0;
            busy_ch_r <= 1'b0;
         end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            ack_ch_r  <= (state_nxt_s == ST_HIGH) || (state_nxt_s == ST_FALL);
            busy_ch_r <= (state_nxt_s == ST_RISE) || (state_nxt_s == ST_FALL);
         end
      end

      assign ack_vec_s[g]  = ack_ch_r;
      assign busy_vec_s[g] = busy_ch_r;
   end

   assign ack     = ack_vec_s;
   assign busy    = busy_vec_s;
   assign dly_cur = dly_cur_r;
   assign cfg_err = cfg_err_r;

endmodule

// File: tb/tb_req_delay_line.sv
// Directed self-checking bench for req_delay_line: a default-parameter instance
// plus a D=0 / no-fall-tracking instance with MAX_DELAY=14 for the out-of-range load.
module tb_req_delay_line;

   logic       clk;
   logic       rst_n;
   logic       en, cfg_load, cfg_err;
   logic [3:0] cfg_delay, dly_cur, req, ack, busy;
   logic       en_b, cfg_load_b, cfg_err_b;
   logic [3:0] cfg_delay_b, dly_cur_b, req_b, ack_b, busy_b;

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0] seq_b [7] = '{4'hF, 4'h0, 4'hA, 4'h5, 4'hF, 4'h3, 4'h0};

   req_delay_line u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .cfg_load(cfg_load), .cfg_delay(cfg_delay),
      .cfg_err(cfg_err), .dly_cur(dly_cur), .req(req), .ack(ack), .busy(busy)
   );

   req_delay_line #(.CHANNELS(4), .MAX_DELAY(14), .DEFAULT_DELAY(0), .TRACK_FALL(1'b0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .cfg_load(cfg_load_b), .cfg_delay(cfg_delay_b),
      .cfg_err(cfg_err_b), .dly_cur(dly_cur_b), .req(req_b), .ack(ack_b), .busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; req = 4'hF; cfg_load = 1'b0; cfg_delay = 4'd0;
      en_b = 1'b1; req_b = 4'h0; cfg_load_b = 1'b0; cfg_delay_b = 4'd0;
      tick(); tick();
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_dly", 32'(dly_cur), 32'd12);
      chk("rst_cfg_err", 32'(cfg_err), 32'h0);
      chk("rst_dly_b", 32'(dly_cur_b), 32'd0);

      // default delay 12 from the first sampled edge after release
      rst_n = 1'b1;
      tick();
      chk("d12_busy_t0", 32'(busy), 32'hF);
      chk("d12_ack_t0", 32'(ack), 32'h0);
      repeat (11) tick();
      chk("d12_ack_t11", 32'(ack), 32'h0);
      tick();
      chk("d12_ack_t12", 32'(ack), 32'hF);
      chk("d12_busy_t12", 32'(busy), 32'h0);
      req = 4'h0; en = 1'b0;
      tick();
      chk("flush_high_ack", 32'(ack), 32'h0);
      chk("flush_high_busy", 32'(busy), 32'h0);

      // D=3 edge delays on channel 0
      en = 1'b1; cfg_load = 1'b1; cfg_delay = 4'd3;
      tick();
      chk("load3_dly", 32'(dly_cur), 32'd3);
      chk("load3_err", 32'(cfg_err), 32'h0);
      cfg_load = 1'b0; req = 4'b0001;
      tick();
      chk("d3_busy_t0", 32'(busy), 32'h1);
      chk("d3_ack_t0", 32'(ack), 32'h0);
      tick(); tick();
      chk("d3_busy_t2", 32'(busy), 32'h1);
      chk("d3_ack_t2", 32'(ack), 32'h0);
      tick();
      chk("d3_ack_t3", 32'(ack), 32'h1);
      chk("d3_busy_t3", 32'(busy), 32'h0);
      repeat (6) tick();
      chk("d3_ack_t9", 32'(ack), 32'h1);
      req = 4'h0;
      tick();
      chk("d3_fall_ack_t10", 32'(ack), 32'h1);
      chk("d3_fall_busy_t10", 32'(busy), 32'h1);
      tick(); tick();
      chk("d3_fall_ack_t12", 32'(ack), 32'h1);
      chk("d3_fall_busy_t12", 32'(busy), 32'h1);
      tick();
      chk("d3_fall_ack_t13", 32'(ack), 32'h0);
      chk("d3_fall_busy_t13", 32'(busy), 32'h0);

      // D=5 glitch filter on channel 1
      cfg_load = 1'b1; cfg_delay = 4'd5;
      tick();
      chk("load5_dly", 32'(dly_cur), 32'd5);
      cfg_load = 1'b0; req = 4'b0010;
      tick();
      chk("glitch_busy_t0", 32'(busy), 32'h2);
      tick(); tick();
      chk("glitch_busy_t2", 32'(busy), 32'h2);
      req = 4'h0;
      tick();
      chk("glitch_busy_drop", 32'(busy), 32'h0);
      chk("glitch_ack_drop", 32'(ack), 32'h0);
      repeat (5) tick();
      chk("glitch_ack_late", 32'(ack), 32'h0);
      req = 4'b0010;
      repeat (5) tick();
      chk("gap_ack_t4", 32'(ack), 32'h0);
      tick();
      chk("gap_ack_t5", 32'(ack), 32'h2);
      req = 4'h0;
      tick();
      chk("gap_ack_low1", 32'(ack), 32'h2);
      chk("gap_busy_low1", 32'(busy), 32'h2);
      tick();
      chk("gap_ack_low2", 32'(ack), 32'h2);
      req = 4'b0010;
      tick();
      chk("gap_ack_back", 32'(ack), 32'h2);
      chk("gap_busy_back", 32'(busy), 32'h0);
      repeat (6) tick();
      chk("gap_ack_hold", 32'(ack), 32'h2);
      req = 4'h0; en = 1'b0;
      tick();
      chk("gap_flush_ack", 32'(ack), 32'h0);

      // D=8 flush in mid-RISE, then fresh RISE
      en = 1'b1; cfg_load = 1'b1; cfg_delay = 4'd8;
      tick();
      chk("load8_dly", 32'(dly_cur), 32'd8);
      cfg_load = 1'b0; req = 4'hF;
      tick();
      chk("flush_busy_t0", 32'(busy), 32'hF);
      repeat (3) tick();
      en = 1'b0;
      tick();
      chk("flush_ack", 32'(ack), 32'h0);
      chk("flush_busy", 32'(busy), 32'h0);
      en = 1'b1;
      tick();
      chk("reen_busy_t0", 32'(busy), 32'hF);
      chk("reen_ack_t0", 32'(ack), 32'h0);
      repeat (7) tick();
      chk("reen_ack_t7", 32'(ack), 32'h0);
      tick();
      chk("reen_ack_t8", 32'(ack), 32'hF);
      chk("reen_busy_t8", 32'(busy), 32'h0);

      // config rejected while busy, accepted when idle
      en = 1'b0;
      tick();
      en = 1'b1; req = 4'b0100;
      tick();
      chk("cfg_busy2", 32'(busy), 32'h4);
      cfg_load = 1'b1; cfg_delay = 4'd2;
      tick();
      chk("cfg_busy_err", 32'(cfg_err), 32'h1);
      chk("cfg_busy_dly", 32'(dly_cur), 32'd8);
      cfg_load = 1'b0;
      tick();
      chk("cfg_err_pulse_end", 32'(cfg_err), 32'h0);
      chk("cfg_busy_dly_keep", 32'(dly_cur), 32'd8);
      en = 1'b0; req = 4'h0;
      tick();
      en = 1'b1; cfg_load = 1'b1; cfg_delay = 4'd2;
      tick();
      chk("cfg_idle_dly", 32'(dly_cur), 32'd2);
      chk("cfg_idle_err", 32'(cfg_err), 32'h0);

      // rise starting on the same edge as a load uses the old D=2
      cfg_delay = 4'd4; req = 4'b1000;
      tick();
      chk("oldd_dly", 32'(dly_cur), 32'd4);
      chk("oldd_busy", 32'(busy), 32'h8);
      cfg_load = 1'b0;
      tick();
      chk("oldd_ack_t1", 32'(ack), 32'h0);
      tick();
      chk("oldd_ack_t2", 32'(ack), 32'h8);
      chk("oldd_busy_t2", 32'(busy), 32'h0);

      // out-of-range load on the MAX_DELAY=14 instance
      cfg_load_b = 1'b1; cfg_delay_b = 4'd15;
      tick();
      chk("b_range_err", 32'(cfg_err_b), 32'h1);
      chk("b_range_dly", 32'(dly_cur_b), 32'd0);
      cfg_load_b = 1'b0;
      tick();
      chk("b_range_err_end", 32'(cfg_err_b), 32'h0);

      // D=0, no fall tracking: ack follows req one cycle later
      for (int i = 0; i < 7; i++) begin
         req_b = seq_b[i];
         tick();
         chk("b_follow_ack", 32'(ack_b), 32'(seq_b[i]));
         chk("b_follow_busy", 32'(busy_b), 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
